// File: rtl/demux_pkg.sv
// Shared defaults and select decode for the 1-to-4 demultiplexer.
package demux_pkg;

    localparam int DATA_WIDTH_DEF = 1;
    localparam int CNT_WIDTH_DEF  = 16;
    localparam int NUM_OUT        = 4;

    typedef enum logic [1:0] {
        SEL_OUT_1 = 2'd0,
        SEL_OUT_2 = 2'd1,
        SEL_OUT_3 = 2'd2,
        SEL_OUT_4 = 2'd3
    } sel_idx_t;

    function automatic logic [NUM_OUT-1:0] sel_onehot(input sel_idx_t sel);
        logic [NUM_OUT-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_chan_cnt.sv
// Per-output transfer counter: saturates at all-ones, clear beats increment.
module demux_chan_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != '1)) begin
            o_cnt <= o_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/demux_1_to_4.sv
// Registered 1-to-4 demultiplexer with per-output saturating transfer counters.
module demux_1_to_4
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_sel_1,
    input  logic                  i_sel_2,
    input  logic                  i_clr_cnt,
    output logic [DATA_WIDTH-1:0] o_data_1,
    output logic [DATA_WIDTH-1:0] o_data_2,
    output logic [DATA_WIDTH-1:0] o_data_3,
    output logic [DATA_WIDTH-1:0] o_data_4,
    output logic                  o_valid_1,
    output logic                  o_valid_2,
    output logic                  o_valid_3,
    output logic                  o_valid_4,
    output logic [CNT_WIDTH-1:0]  o_cnt_1,
    output logic [CNT_WIDTH-1:0]  o_cnt_2,
    output logic [CNT_WIDTH-1:0]  o_cnt_3,
    output logic [CNT_WIDTH-1:0]  o_cnt_4
);

    // Handshake: i_valid qualifies i_data with no ready, so every valid word is
    // accepted; data is routed even when invalid, and o_valid_N is one-hot or zero.
    sel_idx_t           sel;
    logic [NUM_OUT-1:0] hit;
    logic [NUM_OUT-1:0] inc;

    assign sel = sel_idx_t'({i_sel_2, i_sel_1});
    assign hit = sel_onehot(sel);
    assign inc = hit & {NUM_OUT{i_valid}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_1  <= '0;
            o_data_2  <= '0;
            o_data_3  <= '0;
            o_data_4  <= '0;
            o_valid_1 <= 1'b0;
            o_valid_2 <= 1'b0;
            o_valid_3 <= 1'b0;
            o_valid_4 <= 1'b0;
        end else begin
            o_data_1  <= hit[0] ? i_data : '0;
            o_data_2  <= hit[1] ? i_data : '0;
            o_data_3  <= hit[2] ? i_data : '0;
            o_data_4  <= hit[3] ? i_data : '0;
            o_valid_1 <= inc[0];
            o_valid_2 <= inc[1];
            o_valid_3 <= inc[2];
            o_valid_4 <= inc[3];
        end
    end

    demux_chan_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_1 (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (i_clr_cnt),
        .i_inc  (inc[0]),
        .o_cnt  (o_cnt_1)
    );

    demux_chan_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_2 (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (i_clr_cnt),
        .i_inc  (inc[1]),
        .o_cnt  (o_cnt_2)
    );

    demux_chan_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_3 (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (i_clr_cnt),
        .i_inc  (inc[2]),
        .o_cnt  (o_cnt_3)
    );

    demux_chan_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_4 (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (i_clr_cnt),
        .i_inc  (inc[3]),
        .o_cnt  (o_cnt_4)
    );

endmodule

// File: tb/tb_demux_1_to_4.sv
// Scoreboard bench for demux_1_to_4 (8-bit data, 4-bit counters to reach saturation quickly).
module tb_demux_1_to_4;

    localparam int DW = 8;
    localparam int CW = 4;
    localparam int W  = 4*DW + 4 + 4*CW;

    logic          i_clk;
    logic          i_rst_n;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          i_sel_1;
    logic          i_sel_2;
    logic          i_clr_cnt;
    logic [DW-1:0] o_data_1, o_data_2, o_data_3, o_data_4;
    logic          o_valid_1, o_valid_2, o_valid_3, o_valid_4;
    logic [CW-1:0] o_cnt_1, o_cnt_2, o_cnt_3, o_cnt_4;

    logic [W-1:0]  exp_q[$];
    logic [CW-1:0] m_cnt[4];
    int            n_total;
    int            n_pass;

    demux_1_to_4 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_sel_1  (i_sel_1),
        .i_sel_2  (i_sel_2),
        .i_clr_cnt(i_clr_cnt),
        .o_data_1 (o_data_1),
        .o_data_2 (o_data_2),
        .o_data_3 (o_data_3),
        .o_data_4 (o_data_4),
        .o_valid_1(o_valid_1),
        .o_valid_2(o_valid_2),
        .o_valid_3(o_valid_3),
        .o_valid_4(o_valid_4),
        .o_cnt_1  (o_cnt_1),
        .o_cnt_2  (o_cnt_2),
        .o_cnt_3  (o_cnt_3),
        .o_cnt_4  (o_cnt_4)
    );

    // Clock and reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [W-1:0] obs_vec();
        return {o_data_4, o_data_3, o_data_2, o_data_1,
                o_valid_4, o_valid_3, o_valid_2, o_valid_1,
                o_cnt_4, o_cnt_3, o_cnt_2, o_cnt_1};
    endfunction

    // Driver: applies one word, pushes the expected post-edge outputs, steps past the edge.
    task automatic drive(input logic [1:0] sel, input logic valid,
                         input logic [DW-1:0] data, input logic clr);
        logic [DW-1:0] ed[4];
        logic [3:0]    ev;
        i_sel_1   = sel[0];
        i_sel_2   = sel[1];
        i_valid   = valid;
        i_data    = data;
        i_clr_cnt = clr;
        for (int k = 0; k < 4; k++) begin
            ed[k] = (k == int'(sel)) ? data : '0;
            ev[k] = valid && (k == int'(sel));
        end
        if (clr) begin
            for (int k = 0; k < 4; k++) m_cnt[k] = '0;
        end else if (valid && (m_cnt[sel] != 4'hF)) begin
            m_cnt[sel] = m_cnt[sel] + 4'd1;
        end
        exp_q.push_back({ed[3], ed[2], ed[1], ed[0], ev,
                         m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] obs;
        #2;
        obs = obs_vec();
        n_total++;
        if (obs !== '0) $display("FAIL reset_state got %h exp 0", obs);
        else n_pass++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_sweep(input logic valid);
        logic [W-1:0] obs, exp;
        for (int s = 0; s < 4; s++) begin
            drive(2'(s), valid, 8'h01, 1'b0);
            exp = exp_q.pop_front();
            obs = obs_vec();
            n_total++;
            if (obs !== exp) $display("FAIL sweep_v%0d_sel%0d got %h exp %h", valid, s, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_count_clear();
        logic [W-1:0] obs, exp;
        for (int i = 0; i < 5; i++) begin
            drive(2'b10, 1'b1, 8'(8'hA0 + i), 1'b0);
            exp = exp_q.pop_front();
            obs = obs_vec();
            n_total++;
            if (obs !== exp) $display("FAIL count3_step%0d got %h exp %h", i, obs, exp);
            else n_pass++;
        end
        n_total++;
        if (o_cnt_3 !== 4'd5 || o_cnt_1 !== 4'd0 || o_cnt_2 !== 4'd0 || o_cnt_4 !== 4'd0)
            $display("FAIL count3_total got %0d/%0d/%0d/%0d exp 0/0/5/0",
                     o_cnt_1, o_cnt_2, o_cnt_3, o_cnt_4);
        else n_pass++;
        drive(2'b10, 1'b1, 8'h5A, 1'b1);
        exp = exp_q.pop_front();
        obs = obs_vec();
        n_total++;
        if (obs !== exp) $display("FAIL clear_over_inc got %h exp %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_saturate();
        logic [W-1:0] obs, exp;
        for (int i = 0; i < 20; i++) begin
            drive(2'b11, 1'b1, 8'(i), 1'b0);
            exp = exp_q.pop_front();
            obs = obs_vec();
            n_total++;
            if (obs !== exp) $display("FAIL sat4_step%0d got %h exp %h", i, obs, exp);
            else n_pass++;
        end
        n_total++;
        if (o_cnt_4 !== 4'd15) $display("FAIL sat4_hold got %0d exp 15", o_cnt_4);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic [W-1:0] obs, exp;
        drive(2'b01, 1'b1, 8'hC3, 1'b0);
        exp = exp_q.pop_front();
        obs = obs_vec();
        n_total++;
        if (obs !== exp || o_valid_2 !== 1'b1) $display("FAIL pre_reset got %h exp %h", obs, exp);
        else n_pass++;
        #2;
        i_rst_n = 1'b0;
        for (int k = 0; k < 4; k++) m_cnt[k] = '0;
        #1;
        obs = obs_vec();
        n_total++;
        if (obs !== '0) $display("FAIL reset_async got %h exp 0", obs);
        else n_pass++;
        i_valid = 1'b1;
        i_sel_1 = 1'b1;
        i_sel_2 = 1'b0;
        i_data  = 8'hFF;
        @(posedge i_clk);
        #1;
        obs = obs_vec();
        n_total++;
        if (obs !== '0) $display("FAIL reset_held got %h exp 0", obs);
        else n_pass++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        obs = obs_vec();
        n_total++;
        if (obs !== '0) $display("FAIL reset_released got %h exp 0", obs);
        else n_pass++;
        drive(2'b00, 1'b1, 8'h3C, 1'b0);
        exp = exp_q.pop_front();
        obs = obs_vec();
        n_total++;
        if (obs !== exp) $display("FAIL post_reset got %h exp %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] obs, exp;
        logic [3:0]   v;
        for (int i = 0; i < 1000; i++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
            exp = exp_q.pop_front();
            obs = obs_vec();
            n_total++;
            if (obs !== exp) $display("FAIL random_%0d got %h exp %h", i, obs, exp);
            else n_pass++;
            v = {o_valid_4, o_valid_3, o_valid_2, o_valid_1};
            n_total++;
            if ($countones(v) > 1) $display("FAIL onehot_%0d got %b exp at most one bit", i, v);
            else n_pass++;
        end
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        i_rst_n   = 1'b0;
        i_data    = '0;
        i_valid   = 1'b0;
        i_sel_1   = 1'b0;
        i_sel_2   = 1'b0;
        i_clr_cnt = 1'b0;
        for (int k = 0; k < 4; k++) m_cnt[k] = '0;
        test_reset();
        test_sweep(1'b1);
        test_sweep(1'b0);
        drive(2'b00, 1'b0, 8'h00, 1'b1);
        void'(exp_q.pop_front());
        test_count_clear();
        test_saturate();
        test_reset_midstream();
        test_random();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL queue_drain got %0d exp 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/demux_1_to_4.md
DEMUX_1_TO_4 -- requirements
Module: demux_1_to_4

Interface
REQ-001 Parameter DATA_WIDTH, default 1, width of the data path and of every o_data_N.
REQ-002 Parameter CNT_WIDTH, default 16, width of each per-output transfer counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port i_clk, input, 1, sole clock; all state rises on its positive edge.
REQ-005 Port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port i_data, input, DATA_WIDTH, word to route.
REQ-007 Port i_valid, input, 1, i_data qualifier; no backpressure.
REQ-008 Port i_sel_1, input, 1, select bit 0 (LSB).
REQ-009 Port i_sel_2, input, 1, select bit 1 (MSB).
REQ-010 Port i_clr_cnt, input, 1, synchronous clear of all transfer counters.
REQ-011 Ports o_data_1..o_data_4, output, DATA_WIDTH each, routed data.
REQ-012 Ports o_valid_1..o_valid_4, output, 1 each, per-output qualifier.
REQ-013 Ports o_cnt_1..o_cnt_4, output, CNT_WIDTH each, accepted-word count per output.

Function
REQ-014 Select index SHALL be {i_sel_2,i_sel_1}: 00->output 1, 01->output 2, 10->output 3, 11->output 4.
REQ-015 Data, valid and select SHALL be sampled together on each i_clk rising edge; outputs registered, latency exactly 1 cycle.
REQ-016 On the edge after sampling, the selected o_data_N SHALL equal sampled i_data; all three non-selected o_data SHALL be 0.
REQ-017 Data routing SHALL occur regardless of i_valid (pass-through demux); with i_valid=1 the selected o_valid_N SHALL be 1, all other o_valid 0.
REQ-018 With i_valid=0 every o_valid_N SHALL be 0 in the following cycle.
REQ-019 At most one o_valid_N SHALL be 1 in any cycle (one-hot or zero).
REQ-020 Select changes SHALL take effect on the very next edge; no hold, no glitch on registered outputs.
REQ-021 o_cnt_N SHALL increment by 1 on each edge where i_valid=1 and the select addresses output N.
REQ-022 Counters SHALL saturate at 2^CNT_WIDTH-1 (no wrap).
REQ-023 i_clr_cnt=1 SHALL set all counters to 0 on the next edge, taking priority over a simultaneous increment.
REQ-024 X/Z on select is out of scope; synthesis needs no handling.

Reset
REQ-025 i_rst_n low SHALL immediately (asynchronously) force all o_data to 0, all o_valid to 0, all o_cnt to 0.
REQ-026 Reset release SHALL be synchronous-safe; the first sample is taken on the first i_clk rising edge with i_rst_n high.
REQ-027 Reset asserted mid-stream SHALL discard the in-flight word; no output asserts valid until a new word is sampled.

Structure
REQ-028 Package demux_pkg SHALL hold DATA_WIDTH/CNT_WIDTH defaults, NUM_OUT=4 and the 2-bit select index type.
REQ-029 One sub-module, demux_chan_cnt (saturating counter with clear and increment enable), SHALL be instantiated four times.
REQ-030 Routing decode and output registers SHALL reside in demux_1_to_4 itself.

Verification
REQ-031 i_data=1, i_valid=1, sel sweep 00,01,10,11 on successive edges -> o_data_1,2,3,4 = 1 in turn, one cycle later; others 0.
REQ-032 Same sweep with i_valid=0 -> o_data routed as above, all o_valid 0, counters unchanged.
REQ-033 Hold sel=10, i_valid=1 for 5 cycles -> o_cnt_3=5, other counters 0; then i_clr_cnt with valid -> all counters 0.
REQ-034 CNT_WIDTH=4, 20 valid words to output 4 -> o_cnt_4 holds at 15.
REQ-035 Assert i_rst_n low between edges with o_valid_2=1 -> all outputs 0 immediately, stay 0 until first post-release edge.
REQ-036 Random sel/valid/data for 1000 cycles -> scoreboard matches REQ-014..019, one-hot o_valid never violated.
